// File: rtl/register_serial_in_parallel_out_pkg.sv
// Shared definitions for the serial-in / parallel-out receiver and the
// modulo detector chain.
//   state_t    : receiver FSM states (IDLE, SHIFT, HOLD)
//   MOD_BASE   : modulus tracked by the optional remainder accumulator
//   mod5_step  : one MSB-first step of a running mod-5 residue, (2r+b)%5
package register_serial_in_parallel_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int MOD_BASE = 5;

    // r is always a reduced residue (0..4), so 2r+b <= 9 and a single
    // conditional subtraction is enough to bring it back into range.
    function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
        logic [3:0] s;
        s = {r, 1'b0} + {3'b000, b};
        if (s >= 4'(MOD_BASE))
            s = s - 4'(MOD_BASE);
        return s[2:0];
    endfunction

endpackage

// File: rtl/register_serial_in_parallel_out_modulo_accumulator.sv
// modulo_accumulator: running mod-5 residue of an MSB-first bit stream.
// Only built when REGISTER_SIPO_MODULO_CHECK_EN is defined.
//   clock  : system clock, rising edge
//   reset  : synchronous active-high clear
//   clear  : synchronous clear at the start of a frame
//   step   : fold bit_in into the residue this cycle
//   bit_in : serial data bit
//   r_next : residue including bit_in, used to latch the final remainder
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
module modulo_accumulator
    import register_serial_in_parallel_out_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       step,
    input  logic       bit_in,
    output logic [2:0] r_next
);

    logic [2:0] r;

    assign r_next = mod5_step(r, bit_in);

    always_ff @(posedge clock) begin
        if (reset || clear)
            r <= '0;
        else if (step)
            r <= r_next;
    end

endmodule
`endif

// File: rtl/register_serial_in_parallel_out.sv
// register_serial_in_parallel_out: collects WIDTH bits MSB-first from a
// serial stream and hands the assembled word out with a valid/ready pair.
// Optional feature macro: REGISTER_SIPO_MODULO_CHECK_EN (adds remainder).
//   clock        : system clock, rising edge
//   reset        : synchronous active-high reset
//   start        : begin a new frame (ignored in HOLD unless out_ready)
//   en           : shift enable, honoured only in SHIFT
//   input_bit    : serial data, MSB first
//   out_ready    : consumer accepts the held word
//   parallel_out : assembled word, loaded only on entry to HOLD
//   out_valid    : high in HOLD
//   busy         : high in SHIFT
//   overrun      : sticky, set by start while a word is held unconsumed
//   remainder    : (feature) word value mod 5, latched with parallel_out
module register_serial_in_parallel_out
    import register_serial_in_parallel_out_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             input_bit,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
    ,
    output logic [2:0]       remainder
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state, state_next;
    // Only WIDTH-1 bits are stored: the final bit goes straight from
    // input_bit into parallel_out, so the MSB of a full-width shifter
    // would never be read.
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] shreg_ext;
    logic [CNT_W-1:0] count;
    logic             frame_begin;
    logic             sample;
    logic             last_bit;

    assign shreg_ext = {shreg, input_bit};
    assign busy      = (state == SHIFT);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // start outranks en in SHIFT; in HOLD it only counts once the word
    // is consumed on the same cycle.
    always_comb begin
        state_next  = state;
        frame_begin = 1'b0;
        sample      = 1'b0;
        last_bit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    frame_begin = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    frame_begin = 1'b1;
                end else if (en) begin
                    sample = 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        last_bit   = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        frame_begin = 1'b1;
                        state_next  = SHIFT;
                    end else begin
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg        <= '0;
            count        <= '0;
            parallel_out <= '0;
            overrun      <= 1'b0;
        end else begin
            if (frame_begin) begin
                shreg <= '0;
                count <= '0;
            end else if (sample) begin
                shreg <= shreg_ext[WIDTH-2:0];
                count <= last_bit ? '0 : count + CNT_W'(1);
            end
            if (last_bit)
                parallel_out <= shreg_ext;
            if (state == HOLD && start && !out_ready)
                overrun <= 1'b1;
        end
    end

`ifdef REGISTER_SIPO_MODULO_CHECK_EN
    logic [2:0] acc_next;

    modulo_accumulator u_acc (
        .clock  (clock),
        .reset  (reset),
        .clear  (frame_begin),
        .step   (sample),
        .bit_in (input_bit),
        .r_next (acc_next)
    );

    always_ff @(posedge clock) begin
        if (reset)
            remainder <= '0;
        else if (last_bit)
            remainder <= acc_next;
    end
`endif

endmodule

// File: tb/tb_register_serial_in_parallel_out.sv
module tb_register_serial_in_parallel_out;

    logic       clock;
    logic       reset;
    logic       start;
    logic       en;
    logic       input_bit;
    logic       out_ready;
    logic [7:0] parallel_out;
    logic       out_valid;
    logic       busy;
    logic       overrun;
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
    logic [2:0] remainder;
`endif

    int errs;
    int checks;

    register_serial_in_parallel_out #(.WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .en           (en),
        .input_bit    (input_bit),
        .out_ready    (out_ready),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
        ,
        .remainder    (remainder)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            en        = 1'b1;
            input_bit = w[7 - i];
            tick();
        end
        en = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (parallel_out !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", parallel_out); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun: got %b want 0", overrun); end
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
        checks++; if (remainder !== 3'd0) begin errs++; $display("FAIL reset_rem: got %0d want 0", remainder); end
`endif
    endtask

    task automatic test_basic();
        begin_frame();
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy: got %b want 1", busy); end
        send_bits(8'hA5, 0, 6);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
        send_bits(8'hA5, 7, 7);
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (parallel_out !== 8'hA5) begin errs++; $display("FAIL basic_data: got %h want a5", parallel_out); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_hold: got %b want 0", busy); end
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
        checks++; if (remainder !== 3'd0) begin errs++; $display("FAIL basic_rem: got %0d want 0", remainder); end
`endif
        consume();
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_consume_valid: got %b want 0", out_valid); end
        checks++; if (parallel_out !== 8'hA5) begin errs++; $display("FAIL basic_keep_data: got %h want a5", parallel_out); end
    endtask

    task automatic test_stall();
        begin_frame();
        send_bits(8'h3D, 0, 3);
        for (int s = 0; s < 3; s++) begin
            en        = 1'b0;
            input_bit = s[0];
            tick();
            checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL stall_state: got busy=%b valid=%b want busy=1 valid=0", busy, out_valid); end
        end
        send_bits(8'h3D, 4, 6);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stall_early_valid: got %b want 0", out_valid); end
        send_bits(8'h3D, 7, 7);
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stall_valid: got %b want 1", out_valid); end
        checks++; if (parallel_out !== 8'h3D) begin errs++; $display("FAIL stall_data: got %h want 3d", parallel_out); end
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
        checks++; if (remainder !== 3'd1) begin errs++; $display("FAIL stall_rem: got %0d want 1", remainder); end
`endif
        consume();
    endtask

    task automatic test_backpressure();
        begin_frame();
        send_bits(8'hA5, 0, 7);
        out_ready = 1'b0;
        checks++; if (overrun !== 1'b0) begin errs++; $display("FAIL bp_overrun_pre: got %b want 0", overrun); end
        for (int c = 0; c < 5; c++) begin
            start = (c == 1);
            tick();
            start = 1'b0;
            checks++; if (parallel_out !== 8'hA5) begin errs++; $display("FAIL bp_data: got %h want a5", parallel_out); end
            checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL bp_state: got valid=%b busy=%b want valid=1 busy=0", out_valid, busy); end
        end
        checks++; if (overrun !== 1'b1) begin errs++; $display("FAIL bp_overrun: got %b want 1", overrun); end
        consume();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL bp_idle: got valid=%b busy=%b want 0 0", out_valid, busy); end
        checks++; if (overrun !== 1'b1) begin errs++; $display("FAIL bp_overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_back_to_back();
        begin_frame();
        send_bits(8'h12, 0, 7);
        checks++; if (parallel_out !== 8'h12) begin errs++; $display("FAIL b2b_first: got %h want 12", parallel_out); end
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL b2b_busy: got busy=%b valid=%b want 1 0", busy, out_valid); end
        checks++; if (parallel_out !== 8'h12) begin errs++; $display("FAIL b2b_keep: got %h want 12", parallel_out); end
        send_bits(8'hFF, 0, 7);
        checks++; if (parallel_out !== 8'hFF || out_valid !== 1'b1) begin errs++; $display("FAIL b2b_second: got %h valid=%b want ff valid=1", parallel_out, out_valid); end
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
        checks++; if (remainder !== 3'd0) begin errs++; $display("FAIL b2b_rem: got %0d want 0", remainder); end
`endif
        consume();
    endtask

    task automatic test_reset_mid();
        begin_frame();
        send_bits(8'hC3, 0, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (parallel_out !== 8'h00) begin errs++; $display("FAIL rmid_data: got %h want 00", parallel_out); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin errs++; $display("FAIL rmid_flags: got valid=%b busy=%b ovr=%b want 0 0 0", out_valid, busy, overrun); end
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
        checks++; if (remainder !== 3'd0) begin errs++; $display("FAIL rmid_rem: got %0d want 0", remainder); end
`endif
        send_bits(8'hFF, 0, 0);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errs++; $display("FAIL rmid_idle_en: got busy=%b valid=%b want 0 0", busy, out_valid); end
        begin_frame();
        send_bits(8'h07, 0, 7);
        checks++; if (parallel_out !== 8'h07 || out_valid !== 1'b1) begin errs++; $display("FAIL rmid_next: got %h valid=%b want 07 valid=1", parallel_out, out_valid); end
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
        checks++; if (remainder !== 3'd2) begin errs++; $display("FAIL rmid_next_rem: got %0d want 2", remainder); end
`endif
        consume();
    endtask

    task automatic test_restart();
        begin_frame();
        send_bits(8'hFF, 0, 2);
        start     = 1'b1;
        en        = 1'b1;
        input_bit = 1'b1;
        tick();
        start = 1'b0;
        en    = 1'b0;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL restart_busy: got %b want 1", busy); end
        send_bits(8'h81, 0, 7);
        checks++; if (parallel_out !== 8'h81 || out_valid !== 1'b1) begin errs++; $display("FAIL restart_data: got %h valid=%b want 81 valid=1", parallel_out, out_valid); end
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
        checks++; if (remainder !== 3'd4) begin errs++; $display("FAIL restart_rem: got %0d want 4", remainder); end
`endif
        consume();
    endtask

    task automatic test_sweep();
        logic [7:0] w;
        for (int x = 0; x < 256; x++) begin
            w = 8'(x);
            begin_frame();
            send_bits(w, 0, 7);
            checks++; if (parallel_out !== w || out_valid !== 1'b1) begin errs++; $display("FAIL sweep_data: got %h valid=%b want %h valid=1", parallel_out, out_valid, w); end
`ifdef REGISTER_SIPO_MODULO_CHECK_EN
            checks++; if (remainder !== 3'(x % 5)) begin errs++; $display("FAIL sweep_rem: got %0d want %0d for %h", remainder, x % 5, w); end
`endif
            consume();
        end
    endtask

    initial begin
        errs      = 0;
        checks    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        en        = 1'b0;
        input_bit = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_restart();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
